seq_divider: RTL and testbench

- Multi-cycle unsigned restoring divider that computes quotient and remainder by repeated subtract-with-borrow.
- Produces one quotient bit per clock. It is the inverse-direction arithmetic companion to the combinational adder/subtractor blocks.
- Sits between an operand producer and a result consumer, with a valid/ready handshake on both sides.

---
 rtl/seq_divider.sv | 126 ++++++++++++
 tb/tb_seq_divider.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// valid/ready handshake on both the operand side and the result side.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_valid,
    input  logic             i_res_ready,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; a producer holds valid (and its data) until that edge.

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;

    assign shifted = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, div_q};
    assign borrow  = diff[WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        div_d   = div_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    div_d = i_divisor;
                    q_d   = i_dividend;
                    r_d   = '0;
                    if (i_divisor == '0) begin
                        // Zero divisor short-circuits straight to a result.
                        state_d = DONE;
                        cnt_d   = '0;
                        quo_d   = '1;
                        rem_d   = i_dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        cnt_d   = CW'(WIDTH);
                        dbz_d   = 1'b0;
                    end
                end
            end
            RUN: begin
                r_d   = borrow ? shifted : diff;
                q_d   = {q_q[WIDTH-2:0], ~borrow};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    quo_d   = q_d;
                    rem_d   = r_d[WIDTH-1:0];
                end
            end
            DONE: begin
                if (i_res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign o_ready       = (state_q == IDLE);
    assign o_valid       = (state_q == DONE);
    assign o_quotient    = quo_q;
    assign o_remainder   = rem_q;
    assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed WIDTH=4 scenarios and a randomized WIDTH=8
// sweep checked against a plain-arithmetic reference.
module tb_seq_divider;

    logic clk;
    logic rst_n;

    logic       v4, rdy4, ov4, rr4, dz4;
    logic [3:0] dvd4, dvs4, q4, r4;

    logic       v8, rdy8, ov8, rr8, dz8;
    logic [7:0] dvd8, dvs8, q8, r8;

    int n_checks;
    int n_err;

    seq_divider #(.WIDTH(4)) u_div4 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (v4),
        .o_ready      (rdy4),
        .i_dividend   (dvd4),
        .i_divisor    (dvs4),
        .o_valid      (ov4),
        .i_res_ready  (rr4),
        .o_quotient   (q4),
        .o_remainder  (r4),
        .o_div_by_zero(dz4)
    );

    seq_divider #(.WIDTH(8)) u_div8 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (v8),
        .o_ready      (rdy8),
        .i_dividend   (dvd8),
        .i_divisor    (dvs8),
        .o_valid      (ov8),
        .i_res_ready  (rr8),
        .o_quotient   (q8),
        .o_remainder  (r8),
        .o_div_by_zero(dz8)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned division; zero divisor yields all ones / dividend.
    function automatic void model8(input logic [7:0] a, input logic [7:0] b,
                                   output logic [7:0] q, output logic [7:0] r,
                                   output logic dz);
        if (b == 8'd0) begin
            q = 8'hFF; r = a; dz = 1'b1;
        end else begin
            q = a / b; r = a % b; dz = 1'b0;
        end
    endfunction

    // One WIDTH=4 operation. press keeps a 7/7 request asserted while the
    // result is stalled, so it is pending once the result is consumed.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input int stall,
                        input logic [3:0] eq, input logic [3:0] er, input logic ed,
                        input bit press);
        int k;
        dvd4 = a; dvs4 = b; v4 = 1'b1;
        k = 0;
        while (!rdy4 && k < 40) begin @(posedge clk); #1; k++; end
        chk("w4_ready_before_accept", 32'(rdy4), 32'd1);
        @(posedge clk); #1;
        v4 = 1'b0; dvd4 = 4'($urandom); dvs4 = 4'($urandom);
        k = 0;
        while (!ov4 && k < 40) begin @(posedge clk); #1; k++; end
        // Edges counted after the accepting edge; a zero divisor is done on it.
        chk("w4_latency", 32'(k), (b == 4'd0) ? 32'd0 : 32'd4);
        chk("w4_quotient", 32'(q4), 32'(eq));
        chk("w4_remainder", 32'(r4), 32'(er));
        chk("w4_div_by_zero", 32'(dz4), 32'(ed));
        for (int s = 0; s < stall; s++) begin
            if (press) begin v4 = 1'b1; dvd4 = 4'd7; dvs4 = 4'd7; end
            else begin dvd4 = 4'($urandom); dvs4 = 4'($urandom); end
            @(posedge clk); #1;
            chk("w4_hold_valid", 32'(ov4), 32'd1);
            chk("w4_hold_not_ready", 32'(rdy4), 32'd0);
            chk("w4_hold_quotient", 32'(q4), 32'(eq));
            chk("w4_hold_remainder", 32'(r4), 32'(er));
        end
        rr4 = 1'b1;
        @(posedge clk); #1;
        rr4 = 1'b0;
        chk("w4_valid_drops", 32'(ov4), 32'd0);
        chk("w4_ready_returns", 32'(rdy4), 32'd1);
        chk("w4_idle_keeps_quotient", 32'(q4), 32'(eq));
        chk("w4_idle_keeps_remainder", 32'(r4), 32'(er));
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b);
        int k;
        int stall;
        logic [7:0] eq, er;
        logic ed;
        model8(a, b, eq, er, ed);
        dvd8 = a; dvs8 = b; v8 = 1'b1;
        k = 0;
        while (!rdy8 && k < 40) begin @(posedge clk); #1; k++; end
        chk("w8_ready_before_accept", 32'(rdy8), 32'd1);
        @(posedge clk); #1;
        v8 = 1'b0; dvd8 = 8'($urandom); dvs8 = 8'($urandom);
        k = 0;
        while (!ov8 && k < 40) begin
            @(posedge clk); #1; k++;
            dvd8 = 8'($urandom); dvs8 = 8'($urandom);
        end
        chk("w8_latency", 32'(k), (b == 8'd0) ? 32'd0 : 32'd8);
        chk("w8_quotient", 32'(q8), 32'(eq));
        chk("w8_remainder", 32'(r8), 32'(er));
        chk("w8_div_by_zero", 32'(dz8), 32'(ed));
        stall = $urandom_range(0, 2);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("w8_hold_valid", 32'(ov8), 32'd1);
            chk("w8_hold_quotient", 32'(q8), 32'(eq));
        end
        rr8 = 1'b1;
        @(posedge clk); #1;
        rr8 = 1'b0;
        chk("w8_valid_drops", 32'(ov8), 32'd0);
    endtask

    initial begin
        logic [7:0] a8, b8;
        n_checks = 0; n_err = 0;
        rst_n = 1'b0;
        v4 = 1'b0; rr4 = 1'b0; dvd4 = '0; dvs4 = '0;
        v8 = 1'b0; rr8 = 1'b0; dvd8 = '0; dvs8 = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_ready", 32'(rdy4), 32'd1);
        chk("reset_valid", 32'(ov4), 32'd0);
        chk("reset_quotient", 32'(q4), 32'd0);
        chk("reset_remainder", 32'(r4), 32'd0);
        chk("reset_div_by_zero", 32'(dz4), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // basic and corner divisions
        run4(4'd13, 4'd3,  0, 4'd4,  4'd1, 1'b0, 1'b0);
        run4(4'd15, 4'd1,  0, 4'd15, 4'd0, 1'b0, 1'b0);
        run4(4'd2,  4'd7,  0, 4'd0,  4'd2, 1'b0, 1'b0);
        run4(4'd15, 4'd15, 0, 4'd1,  4'd0, 1'b0, 1'b0);
        run4(4'd0,  4'd5,  0, 4'd0,  4'd0, 1'b0, 1'b0);

        // divide by zero, then a normal op clears the flag
        run4(4'd5, 4'd0, 0, 4'd15, 4'd5, 1'b1, 1'b0);
        run4(4'd9, 4'd2, 0, 4'd4,  4'd1, 1'b0, 1'b0);

        // backpressure with a pending 7/7 request
        run4(4'd14, 4'd4, 3, 4'd3, 4'd2, 1'b0, 1'b1);
        run4(4'd7,  4'd7, 0, 4'd1, 4'd0, 1'b0, 1'b0);

        // asynchronous reset two edges into a run
        dvd4 = 4'd11; dvs4 = 4'd2; v4 = 1'b1;
        @(posedge clk); #1;
        v4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_ready", 32'(rdy4), 32'd1);
        chk("midrun_reset_valid", 32'(ov4), 32'd0);
        chk("midrun_reset_quotient", 32'(q4), 32'd0);
        chk("midrun_reset_remainder", 32'(r4), 32'd0);
        chk("midrun_reset_div_by_zero", 32'(dz4), 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run4(4'd11, 4'd2, 0, 4'd5, 4'd1, 1'b0, 1'b0);

        // WIDTH=8 random sweep
        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom);
            b8 = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            run8(a8, b8);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
